ahb_arbiter: RTL and testbench



---
 rtl/ahb_pkg.sv | 20 ++
 rtl/ahb_rr_picker.sv | 28 ++
 rtl/ahb_arbiter.sv | 122 ++++++++++++
 tb/tb_ahb_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS encodings and arbiter state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    StPark   = 2'd0,
    StOwn    = 2'd1,
    StLocked = 2'd2
  } arb_state_e;

  // True for transfer types that move data (NONSEQ or SEQ).
  function automatic logic htrans_is_xfer(logic [1:0] t);
    return (t != HTRANS_IDLE) && (t != HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational rotating-priority picker: first requester at or after i_start, wrapping.
module ahb_rr_picker #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_start,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  int unsigned w_cand;

  // Scan NUM_REQ positions starting at i_start; the first hit wins.
  always_comb begin
    w_cand  = 0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = (32'(i_start) + k) % NUM_REQ;
      if (!o_valid && i_req[w_cand[IW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with bus locking, parking and a bounded hold for unlocked bursts.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS    = 4,
  parameter  int unsigned DEFAULT_MASTER = 0,
  parameter  int unsigned MAX_HOLD       = 16,
  localparam int unsigned MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   i_hclk,
  input  logic                   i_hresetn,
  input  logic [NUM_MASTERS-1:0] i_hbusreq,
  input  logic [NUM_MASTERS-1:0] i_hlock,
  input  logic [1:0]             i_htrans,
  input  logic                   i_hready,
  output logic [NUM_MASTERS-1:0] o_hgrant,
  output logic [MW-1:0]          o_hmaster,
  output logic [MW-1:0]          o_hmaster_data,
  output logic                   o_hmastlock
);

  localparam int unsigned            HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]          HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [MW-1:0]          DEF_IDX  = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH   = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e             r_state, w_state_d;
  logic [MW-1:0]          r_owner, w_owner_d;
  logic [NUM_MASTERS-1:0] r_hgrant, w_hgrant_d;
  logic [MW-1:0]          r_hmaster_data;
  logic                   r_hmastlock, w_hmastlock_d;
  logic [HW-1:0]          r_hold_cnt, w_hold_cnt_d;

  logic [MW-1:0] w_start;
  logic [MW-1:0] w_pick_idx;
  logic          w_pick_vld;
  logic          w_owner_req;
  logic          w_owner_lock;
  logic          w_others_req;
  logic          w_hold_expired;
  logic          w_handover;

  // Search begins just past the owner so the owner itself has lowest priority.
  assign w_start = (r_owner == MW'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;

  ahb_rr_picker #(
    .NUM_REQ (NUM_MASTERS)
  ) u_picker (
    .i_req   (i_hbusreq),
    .i_start (w_start),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  assign w_owner_req    = i_hbusreq[r_owner];
  assign w_owner_lock   = i_hlock[r_owner];
  // r_hgrant is always the one-hot of r_owner, so it masks the owner out directly.
  assign w_others_req   = |(i_hbusreq & ~r_hgrant);
  assign w_hold_expired = (r_hold_cnt >= HOLD_MAX) && (i_htrans != HTRANS_SEQ) && w_others_req;
  assign w_handover     = i_hready && (r_state != StLocked) &&
                          ((i_htrans == HTRANS_IDLE) || !w_owner_req || w_hold_expired);

  // Next owner/state, hold counter and lock flag; applied only on hready.
  always_comb begin
    w_state_d     = r_state;
    w_owner_d     = r_owner;
    w_hold_cnt_d  = r_hold_cnt;
    w_hmastlock_d = r_hmastlock;

    if (w_handover) begin
      if (w_pick_vld) begin
        w_owner_d = w_pick_idx;
        w_state_d = StOwn;
      end else begin
        w_owner_d = DEF_IDX;
        w_state_d = StPark;
      end
    end else begin
      unique case (r_state)
        StPark:   if (w_owner_req) w_state_d = StOwn;
        StOwn:    if (w_owner_lock && w_owner_req) w_state_d = StLocked;
        StLocked: if (!w_owner_lock) w_state_d = StOwn;
        default:  w_state_d = StPark;
      endcase
    end

    if (w_owner_d != r_owner) begin
      w_hold_cnt_d = '0;
    end else if ((r_state != StLocked) && htrans_is_xfer(i_htrans) &&
                 (r_hold_cnt < HOLD_MAX)) begin
      w_hold_cnt_d = r_hold_cnt + 1'b1;
    end

    w_hmastlock_d = (w_state_d == StLocked) && w_owner_lock;
    w_hgrant_d    = NUM_MASTERS'(1) << w_owner_d;
  end

  // All arbitration state advances only when the bus completes a transfer.
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_state        <= StPark;
      r_owner        <= DEF_IDX;
      r_hgrant       <= DEF_OH;
      r_hmaster_data <= DEF_IDX;
      r_hmastlock    <= 1'b0;
      r_hold_cnt     <= '0;
    end else if (i_hready) begin
      r_state        <= w_state_d;
      r_owner        <= w_owner_d;
      r_hgrant       <= w_hgrant_d;
      r_hmaster_data <= r_owner;
      r_hmastlock    <= w_hmastlock_d;
      r_hold_cnt     <= w_hold_cnt_d;
    end
  end

  assign o_hgrant       = r_hgrant;
  assign o_hmaster      = r_owner;
  assign o_hmaster_data = r_hmaster_data;
  assign o_hmastlock    = r_hmastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: directed scenarios followed by random traffic.
module tb_ahb_arbiter;

  localparam int N    = 4;
  localparam int DEF  = 0;
  localparam int MAXH = 16;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic       clk     = 1'b0;
  logic       hresetn = 1'b1;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock   = '0;
  logic [1:0] htrans  = '0;
  logic       hready  = 1'b1;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;
  logic       hmastlock;

  ahb_arbiter #(
    .NUM_MASTERS    (N),
    .DEFAULT_MASTER (DEF),
    .MAX_HOLD       (MAXH)
  ) dut (
    .i_hclk         (clk),
    .i_hresetn      (hresetn),
    .i_hbusreq      (hbusreq),
    .i_hlock        (hlock),
    .i_htrans       (htrans),
    .i_hready       (hready),
    .o_hgrant       (hgrant),
    .o_hmaster      (hmaster),
    .o_hmaster_data (hmaster_data),
    .o_hmastlock    (hmastlock)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         phase;
    logic [3:0] grant;
    logic [1:0] master;
    logic [1:0] mdata;
    logic       mlock;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   phase = 0;

  // Reference model: owner index, park/lock flags, hold count, data-phase owner.
  int m_owner;
  int m_hold;
  int m_mdata;
  bit m_park;
  bit m_locked;
  bit m_mlock;

  function automatic void model_reset();
    m_owner  = DEF;
    m_hold   = 0;
    m_mdata  = DEF;
    m_park   = 1'b1;
    m_locked = 1'b0;
    m_mlock  = 1'b0;
  endfunction

  function automatic void model_step(logic [3:0] req, logic [3:0] lk, logic [1:0] tr, bit rdy);
    int  prev;
    int  nxt;
    bit  was_locked;
    bit  others;
    bit  own_req;
    bit  hand;
    bit  xfer;
    if (!rdy) return;
    prev       = m_owner;
    was_locked = m_locked;
    own_req    = req[m_owner];
    others     = (req & ~(4'(1) << m_owner)) != 4'b0;
    xfer       = (tr == T_NSEQ) || (tr == T_SEQ);
    hand       = !m_locked &&
                 ((tr == T_IDLE) || !own_req || (m_hold >= MAXH && tr != T_SEQ && others));
    m_mdata    = m_owner;
    if (hand) begin
      nxt = -1;
      for (int k = 1; k <= N; k++) begin
        if (nxt < 0 && req[(prev + k) % N]) nxt = (prev + k) % N;
      end
      m_locked = 1'b0;
      if (nxt < 0) begin
        m_owner = DEF;
        m_park  = 1'b1;
      end else begin
        m_owner = nxt;
        m_park  = 1'b0;
      end
    end else if (m_locked) begin
      if (!lk[m_owner]) m_locked = 1'b0;
    end else if (m_park) begin
      m_park = 1'b0;
    end else if (lk[m_owner] && own_req) begin
      m_locked = 1'b1;
    end
    if (m_owner != prev) m_hold = 0;
    else if (!was_locked && xfer && m_hold < MAXH) m_hold = m_hold + 1;
    m_mlock = m_locked && lk[m_owner];
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.phase  = phase;
    e.grant  = 4'(1) << m_owner;
    e.master = 2'(m_owner);
    e.mdata  = 2'(m_mdata);
    e.mlock  = m_mlock;
    sb.push_back(e);
  endfunction

  // Called at a falling edge: drive inputs, advance the model, queue the expectation.
  task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                      input bit rdy);
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hready  = rdy;
    model_step(req, lk, tr, rdy);
    push_exp();
    @(negedge clk);
  endtask

  // Drop reset between edges and expect reset values straight away; returns at a falling edge.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    model_reset();
    push_exp();
    hresetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    hresetn = 1'b1;
  endtask

  task automatic chk(input string nm, input int ph, input logic [3:0] got,
                     input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s (phase %0d) at %0t: got %b want %b", nm, ph, $time, got, want);
    end
  endtask

  // Monitor: compare after each active edge out of reset, and right after reset assertion.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk iff hresetn or negedge hresetn);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("hgrant",       e.phase, hgrant,                e.grant);
        chk("hmaster",      e.phase, {2'b00, hmaster},      {2'b00, e.master});
        chk("hmaster_data", e.phase, {2'b00, hmaster_data}, {2'b00, e.mdata});
        chk("hmastlock",    e.phase, {3'b000, hmastlock},   {3'b000, e.mlock});
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    model_reset();
    #2;
    push_exp();
    hresetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    hresetn = 1'b1;

    // Park with no requests.
    phase = 1;
    repeat (2) step(4'b0000, 4'b0000, T_IDLE, 1'b1);

    // Masters 1 and 3 request from park; idle owner hands over 1 -> 3.
    phase = 2;
    step(4'b1010, 4'b0000, T_IDLE, 1'b1);
    step(4'b1010, 4'b0000, T_IDLE, 1'b1);

    // Master 2 streams; master 0 waits until the hold limit and a non-SEQ cycle.
    phase = 3;
    step(4'b0100, 4'b0000, T_IDLE, 1'b1);
    step(4'b0101, 4'b0000, T_NSEQ, 1'b1);
    repeat (20) step(4'b0101, 4'b0000, T_SEQ, 1'b1);
    step(4'b0101, 4'b0000, T_NSEQ, 1'b1);
    step(4'b0001, 4'b0000, T_NSEQ, 1'b1);

    // Master 1 locks; others request long past the hold limit; release rotates to 2.
    phase = 4;
    step(4'b0010, 4'b0000, T_IDLE, 1'b1);
    step(4'b1111, 4'b0010, T_NSEQ, 1'b1);
    for (int i = 0; i < 24; i++) step(4'b1111, 4'b0010, (i % 4 == 0) ? T_NSEQ : T_SEQ, 1'b1);
    step(4'b1111, 4'b0000, T_SEQ, 1'b1);
    step(4'b1111, 4'b0000, T_IDLE, 1'b1);

    // Wait states freeze everything; handover on the first ready cycle.
    phase = 5;
    step(4'b1111, 4'b0000, T_NSEQ, 1'b1);
    repeat (5) step(4'b1011, 4'b0000, T_IDLE, 1'b0);
    step(4'b1011, 4'b0000, T_IDLE, 1'b1);
    step(4'b1011, 4'b0000, T_NSEQ, 1'b1);

    // Reset in the middle of master 3's burst.
    phase = 6;
    step(4'b1000, 4'b0000, T_NSEQ, 1'b1);
    step(4'b1000, 4'b0000, T_SEQ, 1'b1);
    pulse_reset();
    step(4'b0000, 4'b0000, T_IDLE, 1'b1);

    // Random traffic with sparse locks and occasional resets.
    phase = 7;
    for (int i = 0; i < 2000; i++) begin
      if (i % 600 == 599) pulse_reset();
      step(4'($urandom), 4'($urandom & $urandom & $urandom), 2'($urandom),
           ($urandom % 4) != 0);
    end

    @(posedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
